vga_sync_gen: RTL and testbench

- Raster timing generator for the video card; clocked directly by the divided pixel clock produced by the clock divider stage (25 MHz from 100 MHz board clock).
- Produces horizontal/vertical counters, HSYNC/VSYNC, active-video flag and pixel coordinates consumed by the pixel/colour stage and the VGA connector.
- Default timing is 640x480 @ 60 Hz (800 x 525 total).

---
 rtl/vga_sync_gen.sv | 136 +++++++++++++
 tb/tb_vga_sync_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: h/v counters, sync pulses, active-video flag and line/frame pulses.
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_end,
    output logic             frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_end_q, line_end_d;
    logic             frame_start_q, frame_start_d;
    int               hx, vy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first edge after reset only arms the generator; (0,0) is then presented without advancing.
    always_comb begin
        state_d = RUN;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (state_q == RUN) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decode from the next position so every registered output matches pixel_x/pixel_y.
    always_comb begin
        hx            = int'(h_cnt_d);
        vy            = int'(v_cnt_d);
        video_on_d    = (hx < H_ACTIVE) && (vy < V_ACTIVE);
        hsync_d       = ((hx >= HS_START) && (hx < HS_END)) ? H_POL : ~H_POL;
        vsync_d       = ((vy >= VS_START) && (vy < VS_END)) ? V_POL : ~V_POL;
        line_end_d    = (h_cnt_d == H_LAST);
        frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            video_on_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // The frame start produced by the arming edge is not a completed frame, so it is skipped.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d && (state_q == RUN)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = h_cnt_q;
    assign pixel_y     = v_cnt_q;
    assign line_end    = line_end_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for reset/line behaviour, plus a small-raster,
// active-high-polarity instance so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       hs_a, vs_a, vo_a, le_a, fs_a;
    logic [9:0] px_a, py_a;
    logic       hs_b, vs_b, vo_b, le_b, fs_b;
    logic [3:0] px_b, py_b;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int checks = 0;
    int errors = 0;

    vga_sync_gen dut_a (
        .clk(clk), .rst_n(rst_n), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
        .pixel_x(px_a), .pixel_y(py_a), .line_end(le_a), .frame_start(fs_a)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    // 12 x 9 raster: active 6x4, hsync x=8..10, vsync y=5..6, both active-high.
    vga_sync_gen #(
        .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
        .pixel_x(px_b), .pixel_y(py_b), .line_end(le_b), .frame_start(fs_b)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ex, ey, hs_low, nfr, last_fs, vs_cnt;

        // Reset held for 5 clocks
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", hs_a, 1);
        chk("rst_vsync", vs_a, 1);
        chk("rst_video_on", vo_a, 0);
        chk("rst_pixel_x", px_a, 0);
        chk("rst_pixel_y", py_a, 0);
        chk("rst_line_end", le_a, 0);
        chk("rst_frame_start", fs_a, 0);
        chk("rst_b_hsync", hs_b, 0);
        chk("rst_b_vsync", vs_b, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rst_frame_cnt", fc_a, 0);
`endif

        // First edge after release presents (0,0)
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("start_x", px_a, 0);
        chk("start_y", py_a, 0);
        chk("start_video_on", vo_a, 1);
        chk("start_frame_start", fs_a, 1);
        chk("start_line_end", le_a, 0);
        chk("start_hsync", hs_a, 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("start_frame_cnt", fc_a, 0);
`endif

        // Walk line 0 and into line 1 up to (300,1)
        ex = 0; ey = 0; hs_low = 0;
        while (!(ex == 300 && ey == 1)) begin
            @(posedge clk);
            @(negedge clk);
            if (ex == 799) begin ex = 0; ey++; end else ex++;
            chk("a_x", px_a, ex);
            chk("a_y", py_a, ey);
            chk("a_video_on", vo_a, (ex < 640 && ey < 480));
            chk("a_hsync", hs_a, !(ex >= 656 && ex < 752));
            chk("a_vsync", vs_a, 1);
            chk("a_line_end", le_a, (ex == 799));
            chk("a_frame_start", fs_a, 0);
            if (ey == 0 && !hs_a) hs_low++;
        end
        chk("a_hsync_width", hs_low, 96);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("async_x", px_a, 0);
        chk("async_y", py_a, 0);
        chk("async_video_on", vo_a, 0);
        chk("async_hsync", hs_a, 1);
        chk("async_b_x", px_b, 0);
        chk("async_b_y", py_b, 0);
        chk("async_b_hsync", hs_b, 0);
        repeat (2) @(negedge clk);
        chk("held_x", px_a, 0);
        rst_n = 1'b1;

        // Restart and run the small raster for 4 whole frames
        ex = 0; ey = 0; nfr = 0; last_fs = 0; vs_cnt = 0;
        for (int c = 0; c <= 4 * 108; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 0) begin
                chk("restart_a_x", px_a, 0);
                chk("restart_a_frame_start", fs_a, 1);
            end else begin
                if (ex == 11) begin
                    ex = 0;
                    ey = (ey == 8) ? 0 : ey + 1;
                end else begin
                    ex++;
                end
            end
            chk("b_x", px_b, ex);
            chk("b_y", py_b, ey);
            chk("b_video_on", vo_b, (ex < 6 && ey < 4));
            chk("b_hsync", hs_b, (ex >= 8 && ex < 11));
            chk("b_vsync", vs_b, (ey >= 5 && ey < 7));
            chk("b_line_end", le_b, (ex == 11));
            chk("b_frame_start", fs_b, (ex == 0 && ey == 0));
            if (fs_b) begin
                if (nfr > 0) begin
                    chk("b_frame_period", c - last_fs, 108);
                    chk("b_vsync_cycles", vs_cnt, 24);
                end
`ifdef VGA_SYNC_FRAME_CNT_EN
                chk("b_frame_cnt", fc_b, nfr);
`endif
                last_fs = c;
                vs_cnt = 0;
                nfr++;
            end
            if (vs_b) vs_cnt++;
        end
        chk("b_frames_seen", nfr, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
